sm3_msg_padder: RTL and testbench

Upstream stage of the SM3 hash datapath. Accepts an arbitrary-length byte message as a 32-bit big-endian word stream and applies SM3 padding: a 0x80 byte, zero fill, then the 64-bit bit-length. Emits complete 512-bit message blocks over a valid/ready handshake to the compression-round engine. It also flags the first block of a message (engine loads IV) and the last block (engine outputs the digest).

---
 rtl/sm3_pkg.sv | 24 ++
 rtl/sm3_pad_word.sv | 23 ++
 rtl/sm3_msg_padder.sv | 155 +++++++++++++++
 tb/tb_sm3_msg_padder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// Shared SM3 constants and types for the padder and the compression engine.
package sm3_pkg;

  localparam int BLOCK_W = 512;
  localparam int WORD_W  = 32;
  localparam int BLK_WORDS = BLOCK_W / WORD_W;

  localparam logic [255:0] SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  // Length field occupies the last two words; the pad byte fits inline only up to word 13.
  localparam logic [3:0] LEN_HI_IDX     = 4'd14;
  localparam logic [3:0] LEN_LO_IDX     = 4'd15;
  localparam logic [4:0] LAST_INLINE_IDX = 5'd13;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT      = 2'd1,
    PAD2      = 2'd2,
    EMIT_LAST = 2'd3
  } state_t;

endpackage

// File: rtl/sm3_pad_word.sv
// Masks the final message word and inserts the 0x80 pad byte after the last valid byte.
module sm3_pad_word
  import sm3_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        bytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              carry_o
);

  always_comb begin
    word_o  = data_i;
    carry_o = 1'b0;
    case (bytes_i)
      3'd0:    word_o = PAD_WORD;
      3'd1:    word_o = {data_i[31:24], 24'h80_0000};
      3'd2:    word_o = {data_i[31:16], 16'h8000};
      3'd3:    word_o = {data_i[31:8],  8'h80};
      default: carry_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/sm3_msg_padder.sv
// SM3 message padder: packs a 32-bit word stream into padded 512-bit blocks.
module sm3_msg_padder
  import sm3_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last
);

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               first_q, first_d;
  logic               pad2_q, pad2_d;
  logic               defer_q, defer_d;
  logic [WORD_W-1:0]  wbuf_q [BLK_WORDS];
  logic [WORD_W-1:0]  wbuf_d [BLK_WORDS];

  logic [2:0]         nbytes;
  logic [WORD_W-1:0]  pad_word;
  logic               pad_carry;
  logic [4:0]         pad_pos;
  logic [LEN_W-1:0]   len_new;
  logic [63:0]        len_fill_field;
  logic [63:0]        len_cur_field;
  logic               in_fire;
  logic               blk_fire;

  assign nbytes         = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign pad_pos        = {1'b0, idx_q} + {4'd0, pad_carry};
  assign len_new        = len_q + LEN_W'({nbytes, 3'b000});
  assign len_fill_field = 64'(len_new);
  assign len_cur_field  = 64'(len_q);
  assign in_fire        = in_valid && in_ready;
  assign blk_fire       = blk_valid && blk_ready;

  sm3_pad_word u_pad_word (
    .data_i  (in_data),
    .bytes_i (nbytes),
    .word_o  (pad_word),
    .carry_o (pad_carry)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (in_fire && in_last)
          state_d = (pad_pos <= LAST_INLINE_IDX) ? EMIT_LAST : EMIT;
        else if (in_fire && idx_q == 4'd15)
          state_d = EMIT;
      end
      EMIT:      if (blk_fire) state_d = pad2_q ? PAD2 : FILL;
      PAD2:      state_d = EMIT_LAST;
      EMIT_LAST: if (blk_fire) state_d = FILL;
      default:   state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = RST && (state_q == FILL);
    blk_valid = (state_q == EMIT) || (state_q == EMIT_LAST);
    blk_first = blk_valid && first_q;
    blk_last  = (state_q == EMIT_LAST);
    blk_data  = '0;
    for (int i = 0; i < BLK_WORDS; i++)
      blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] = wbuf_q[i];
  end

  always_comb begin
    wbuf_d  = wbuf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    first_d = first_q;
    pad2_d  = pad2_q;
    defer_d = defer_q;
    case (state_q)
      FILL: begin
        if (in_fire && !in_last) begin
          wbuf_d[idx_q] = in_data;
          idx_d         = idx_q + 4'd1;
          len_d         = len_q + LEN_W'(32);
        end else if (in_fire) begin
          for (int i = 0; i < BLK_WORDS; i++)
            if (4'(i) > idx_q) wbuf_d[i] = '0;
          wbuf_d[idx_q] = pad_word;
          idx_d         = 4'd0;
          len_d         = len_new;
          if (pad_carry && idx_q != 4'd15) wbuf_d[idx_q + 4'd1] = PAD_WORD;
          if (pad_pos <= LAST_INLINE_IDX) begin
            wbuf_d[LEN_HI_IDX] = len_fill_field[63:32];
            wbuf_d[LEN_LO_IDX] = len_fill_field[31:0];
          end else begin
            // Length (and possibly the pad byte) goes into a trailing block.
            pad2_d  = 1'b1;
            defer_d = pad_carry && (idx_q == 4'd15);
          end
        end
      end
      EMIT: if (blk_fire) first_d = 1'b0;
      PAD2: begin
        for (int i = 0; i < BLK_WORDS; i++) wbuf_d[i] = '0;
        if (defer_q) wbuf_d[0] = PAD_WORD;
        wbuf_d[LEN_HI_IDX] = len_cur_field[63:32];
        wbuf_d[LEN_LO_IDX] = len_cur_field[31:0];
        pad2_d  = 1'b0;
        defer_d = 1'b0;
      end
      EMIT_LAST: begin
        if (blk_fire) begin
          for (int i = 0; i < BLK_WORDS; i++) wbuf_d[i] = '0;
          idx_d   = 4'd0;
          len_d   = '0;
          first_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q   <= 4'd0;
      len_q   <= '0;
      first_q <= 1'b1;
      pad2_q  <= 1'b0;
      defer_q <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) wbuf_q[i] <= '0;
    end else begin
      idx_q   <= idx_d;
      len_q   <= len_d;
      first_q <= first_d;
      pad2_q  <= pad2_d;
      defer_q <= defer_d;
      for (int i = 0; i < BLK_WORDS; i++) wbuf_q[i] <= wbuf_d[i];
    end
  end

endmodule

// File: tb/tb_sm3_msg_padder.sv
// Directed bench for sm3_msg_padder with hand-computed padded blocks.
module tb_sm3_msg_padder;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int vectors = 0;
  int miscompares = 0;
  int hs_cnt = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (blk_valid && blk_ready) hs_cnt <= hs_cnt + 1;

  sm3_msg_padder dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  function automatic logic [511:0] mk_block(input logic [31:0] w0, input logic [31:0] wi, input int i,
                                            input logic [63:0] len);
    logic [511:0] b;
    b = '0;
    b[511:480] = w0;
    if (i > 0 && i < 14) b[511-32*i -: 32] = wi;
    b[63:0] = len;
    return b;
  endfunction

  // Starts and ends on a falling edge; the word transfers on the rising edge in between.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, output bit to);
    int n;
    to = 0; n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    while (!in_ready && n < 50) begin @(negedge CLK); n++; end
    if (!in_ready) to = 1;
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_block(input int hold, output logic [511:0] d, output logic f, output logic l,
                           output bit to, output bit stable);
    int n;
    to = 0; n = 0; stable = 1;
    blk_ready = 1'b0;
    while (!blk_valid && n < 50) begin @(negedge CLK); n++; end
    if (!blk_valid) to = 1;
    d = blk_data; f = blk_first; l = blk_last;
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      if (!blk_valid || blk_data !== d || blk_first !== f || blk_last !== l || in_ready !== 1'b0) stable = 0;
    end
    blk_ready = 1'b1;
    @(negedge CLK);
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({in_ready, blk_valid, blk_first, blk_last} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0000", {in_ready, blk_valid, blk_first, blk_last});
    end
    vectors++;
    if (blk_data !== 512'd0) begin miscompares++; $display("FAIL reset_data got %h exp 0", blk_data); end
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_abc();
    logic [511:0] d; logic f, l; bit to, st, to2;
    send_word(32'h6162_6300, 1'b1, 3'd3, to);
    vectors++;
    if (to || blk_valid !== 1'b1) begin miscompares++; $display("FAIL abc_latency got valid=%b to=%0d exp 1", blk_valid, to); end
    get_block(0, d, f, l, to2, st);
    vectors++;
    if (d !== mk_block(32'h6162_6380, 32'h0, 0, 64'h18) || to2) begin
      miscompares++; $display("FAIL abc_data got %h", d);
    end
    vectors++;
    if ({f, l} !== 2'b11) begin miscompares++; $display("FAIL abc_flags got %b exp 11", {f, l}); end
  endtask

  task automatic test_empty();
    logic [511:0] d; logic f, l; bit to, st;
    send_word(32'hdead_beef, 1'b1, 3'd0, to);
    get_block(0, d, f, l, to, st);
    vectors++;
    if (d !== mk_block(32'h8000_0000, 32'h0, 0, 64'h0) || {f, l} !== 2'b11 || to) begin
      miscompares++; $display("FAIL empty got %h f=%b l=%b", d, f, l);
    end
  endtask

  task automatic test_clamp();
    logic [511:0] d; logic f, l; bit to, st;
    send_word(32'h1122_3344, 1'b1, 3'd7, to);
    get_block(0, d, f, l, to, st);
    vectors++;
    if (d !== mk_block(32'h1122_3344, 32'h8000_0000, 1, 64'h20) || {f, l} !== 2'b11 || to) begin
      miscompares++; $display("FAIL clamp got %h f=%b l=%b", d, f, l);
    end
  endtask

  task automatic test_55();
    logic [511:0] d, e; logic f, l; bit to, st;
    e = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(32'h0101_0101 * (i + 1), 1'b0, 3'd0, to);
      e[511-32*i -: 32] = 32'h0101_0101 * (i + 1);
    end
    send_word(32'haabb_ccdd, 1'b1, 3'd3, to);
    e[511-32*13 -: 32] = 32'haabb_cc80;
    e[63:0] = 64'h1b8;
    get_block(0, d, f, l, to, st);
    vectors++;
    if (d !== e || to) begin miscompares++; $display("FAIL len55_data got %h exp %h", d, e); end
    vectors++;
    if ({f, l} !== 2'b11) begin miscompares++; $display("FAIL len55_flags got %b exp 11", {f, l}); end
  endtask

  task automatic test_56();
    logic [511:0] d, e; logic f, l; bit to, st;
    e = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(32'h1000_0000 + i, 1'b0, 3'd0, to);
      e[511-32*i -: 32] = 32'h1000_0000 + i;
    end
    send_word(32'h2222_2222, 1'b1, 3'd4, to);
    e[511-32*13 -: 32] = 32'h2222_2222;
    e[511-32*14 -: 32] = 32'h8000_0000;
    get_block(0, d, f, l, to, st);
    vectors++;
    if (d !== e || {f, l} !== 2'b10 || to) begin
      miscompares++; $display("FAIL len56_blk1 got %h f=%b l=%b", d, f, l);
    end
    vectors++;
    if (blk_valid !== 1'b0) begin miscompares++; $display("FAIL len56_pad2_gap got %b exp 0", blk_valid); end
    @(negedge CLK);
    vectors++;
    if (blk_valid !== 1'b1) begin miscompares++; $display("FAIL len56_pad2_latency got %b exp 1", blk_valid); end
    get_block(0, d, f, l, to, st);
    vectors++;
    if (d !== mk_block(32'h0, 32'h0, 0, 64'h1c0) || {f, l} !== 2'b01 || to) begin
      miscompares++; $display("FAIL len56_blk2 got %h f=%b l=%b", d, f, l);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] d, e; logic f, l; bit to, st;
    int hs0;
    hs0 = hs_cnt;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'h6162_6364, (i == 15), 3'd4, to);
      e[511-32*i -: 32] = 32'h6162_6364;
    end
    get_block(5, d, f, l, to, st);
    vectors++;
    if (d !== e || {f, l} !== 2'b10 || to) begin
      miscompares++; $display("FAIL len64_blk1 got %h f=%b l=%b", d, f, l);
    end
    vectors++;
    if (!st) begin miscompares++; $display("FAIL len64_blk1_hold got unstable exp stable"); end
    get_block(5, d, f, l, to, st);
    vectors++;
    if (d !== mk_block(32'h8000_0000, 32'h0, 0, 64'h200) || {f, l} !== 2'b01 || to || !st) begin
      miscompares++; $display("FAIL len64_blk2 got %h f=%b l=%b stable=%0d", d, f, l, st);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if (hs_cnt - hs0 !== 2) begin miscompares++; $display("FAIL len64_handshakes got %0d exp 2", hs_cnt - hs0); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d; logic f, l; bit to, st;
    int hs0;
    for (int i = 0; i < 7; i++) send_word(32'h5555_0000 + i, 1'b0, 3'd0, to);
    in_valid = 1'b1; in_data = 32'h7777_7777; in_last = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({in_ready, blk_valid} !== 2'b00) begin
      miscompares++; $display("FAIL midreset_outputs got %b exp 00", {in_ready, blk_valid});
    end
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    hs0 = hs_cnt;
    send_word(32'h6162_6300, 1'b1, 3'd3, to);
    get_block(0, d, f, l, to, st);
    repeat (3) @(negedge CLK);
    vectors++;
    if (d !== mk_block(32'h6162_6380, 32'h0, 0, 64'h18) || {f, l} !== 2'b11 || to) begin
      miscompares++; $display("FAIL midreset_abc got %h f=%b l=%b", d, f, l);
    end
    vectors++;
    if (hs_cnt - hs0 !== 1) begin miscompares++; $display("FAIL midreset_handshakes got %0d exp 1", hs_cnt - hs0); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_clamp();
    test_55();
    test_56();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
